// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command codes and FSM state encoding shared by the SPI RAM responder and master
package spi_ram_pkg;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_READ, ST_WRITE, ST_IGNORE
  } state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: STAGES-flop synchronizer (i_clk, i_rst, i_d) giving level o_q and one-cycle o_rise/o_fall pulses
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 23LC512-style RAM slave (sclk/cs/mosi in, miso/oe out, dbg backdoor read, wr_strobe, busy)
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_core_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [7:0]            dbg_data_o,
  output logic                  wr_strobe_o,
  output logic                  busy_o
);
  logic [7:0]             r_mem [0:2**ADDR_WIDTH-1];
  state_e                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [2:0]             r_bcnt;
  logic [6:0]             r_rx;
  logic [7:0]             r_sr;
  logic [15:0]            r_addr;
  logic                   r_read, r_miso, r_sel, r_wr_strobe;
  logic                   w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic                   w_cs, w_cs_rise, w_cs_fall, w_mosi;
  logic                   w_byte_done, w_wr;
  logic [7:0]             w_rx_byte;
  logic [15:0]            w_addr_inc;
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .i_clk(clk_core_i), .i_rst(rst_i), .i_d(spi_sclk_i),
    .o_q(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clk(clk_core_i), .i_rst(rst_i), .i_d(spi_cs_i),
    .o_q(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  always_ff @(posedge clk_core_i or posedge rst_i)
    if (rst_i) r_mosi_sync <= '0;
    else r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_byte  = {r_rx, w_mosi};
  assign w_addr_inc = r_addr + 16'd1;
  always_ff @(posedge clk_core_i or posedge rst_i)
    if (rst_i) r_state <= ST_IDLE;
    else r_state <= w_next;
  // IDLE is only left on a CS fall, so the deassert edge alone is enough to hold the FSM idle while deselected
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) w_next = ST_IDLE;
    else
      case (r_state)
        ST_IDLE:    w_next = w_cs_fall ? ST_CMD : ST_IDLE;
        ST_CMD:     w_next = !w_byte_done ? ST_CMD :
                             (w_rx_byte == CMD_READ || w_rx_byte == CMD_WRITE) ? ST_ADDR_HI : ST_IGNORE;
        ST_ADDR_HI: w_next = w_byte_done ? ST_ADDR_LO : ST_ADDR_HI;
        ST_ADDR_LO: w_next = !w_byte_done ? ST_ADDR_LO : r_read ? ST_READ : ST_WRITE;
        default:    w_next = r_state;
      endcase
  end
  always_comb begin
    w_byte_done   = w_sclk_rise && r_bcnt == 3'd0 && !w_cs_rise;
    w_wr          = r_state == ST_WRITE && w_byte_done;
    spi_miso_o    = r_miso;
    spi_miso_oe_o = r_sel;
    busy_o        = r_sel;
    wr_strobe_o   = r_wr_strobe;
    dbg_data_o    = r_mem[dbg_addr_i];
  end
  // In READ the rise counter doubles as the fall phase: count 0 at a fall means the current byte's last bit is going out
  always_ff @(posedge clk_core_i or posedge rst_i)
    if (rst_i) begin
      r_bcnt      <= 3'd7;
      r_rx        <= '0;
      r_sr        <= '0;
      r_addr      <= '0;
      r_read      <= 1'b0;
      r_miso      <= 1'b0;
      r_sel       <= 1'b0;
      r_wr_strobe <= 1'b0;
    end else begin
      r_sel       <= ~w_cs;
      r_wr_strobe <= w_wr;
      if (r_state == ST_IDLE || w_cs_rise) begin
        r_bcnt <= 3'd7;
        r_rx   <= '0;
      end else if (w_sclk_rise) begin
        r_bcnt <= r_bcnt - 3'd1;
        r_rx   <= w_rx_byte[6:0];
      end
      if (r_state == ST_CMD && w_byte_done) r_read <= w_rx_byte == CMD_READ;
      if (r_state == ST_ADDR_HI && w_byte_done) r_addr[15:8] <= w_rx_byte;
      if (r_state == ST_ADDR_LO && w_byte_done) begin
        r_addr[7:0] <= w_rx_byte;
        r_sr        <= r_mem[ADDR_WIDTH'({r_addr[15:8], w_rx_byte})];
      end
      if (w_wr) r_addr <= w_addr_inc;
      if (r_state == ST_READ && w_sclk_fall) begin
        r_miso <= r_sr[7];
        if (r_bcnt == 3'd0) begin
          r_addr <= w_addr_inc;
          r_sr   <= r_mem[w_addr_inc[ADDR_WIDTH-1:0]];
        end else r_sr <= {r_sr[6:0], 1'b0};
      end
      if (w_next != ST_READ) r_miso <= 1'b0;
    end
  always_ff @(posedge clk_core_i)
    if (w_wr) r_mem[r_addr[ADDR_WIDTH-1:0]] <= w_rx_byte;
endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: directed SPI-master bench for spi_ram_responder with immediate-assertion checks
module tb_spi_ram_responder;
  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic       miso, oe, wr_strobe, busy;
  logic [7:0] dbg_addr, dbg_data;
  int         checks = 0, errors = 0, strobes = 0, miso_moves = 0, s0;
  logic [7:0] rx, rx2, acc;

  spi_ram_responder dut (
    .clk_core_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_cs_i(cs), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(oe), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
    .wr_strobe_o(wr_strobe), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_strobe === 1'b1) strobes++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      r[i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (miso !== r[i]) miso_moves++;
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    xfer(b, 8, d);
  endtask

  task automatic sel;
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic desel;
    sclk = 1'b0;
    cs   = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic peek(input logic [7:0] a, input string tag, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {8'h0, dbg_data}, {8'h0, exp});
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", {15'h0, miso}, 16'h0);
    check("rst_oe", {15'h0, oe}, 16'h0);
    check("rst_strobe", {15'h0, wr_strobe}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    s0 = strobes;
    sel();
    check("sel_busy", {15'h0, busy}, 16'h1);
    check("sel_oe", {15'h0, oe}, 16'h1);
    send(8'h02); send(8'h00); send(8'h12); send(8'hA5);
    desel();
    check("wr1_strobes", 16'(strobes - s0), 16'd1);
    peek(8'h12, "wr1_dbg", 8'hA5);
    sel();
    send(8'h03); send(8'h00); send(8'h12); xfer(8'h00, 8, rx);
    desel();
    check("rd1_byte", {8'h0, rx}, 16'h00A5);
    check("rd1_miso_idle", {15'h0, miso}, 16'h0);
    check("rd1_busy_idle", {15'h0, busy}, 16'h0);

    s0 = strobes;
    sel();
    send(8'h02); send(8'h00); send(8'h30); send(8'h11); send(8'h22);
    desel();
    check("wr2_strobes", 16'(strobes - s0), 16'd2);
    peek(8'h31, "wr2_dbg31", 8'h22);
    sel();
    send(8'h03); send(8'h00); send(8'h30); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx2);
    desel();
    check("rd2_byte1", {8'h0, rx}, 16'h0011);
    check("rd2_byte2", {8'h0, rx2}, 16'h0022);

    sel();
    send(8'h02); send(8'h00); send(8'hFF); send(8'h7E); send(8'h81);
    desel();
    peek(8'hFF, "wrap_dbgff", 8'h7E);
    peek(8'h00, "wrap_dbg00", 8'h81);
    sel();
    send(8'h03); send(8'h00); send(8'hFF); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx2);
    desel();
    check("wrap_byte1", {8'h0, rx}, 16'h007E);
    check("wrap_byte2", {8'h0, rx2}, 16'h0081);

    s0 = strobes;
    sel();
    send(8'h05);
    xfer(8'h00, 8, rx); acc = rx;
    xfer(8'h12, 8, rx); acc |= rx;
    xfer(8'hFF, 8, rx); acc |= rx;
    desel();
    check("ign_miso", {8'h0, acc}, 16'h0);
    check("ign_strobes", 16'(strobes - s0), 16'd0);
    peek(8'h12, "ign_dbg12", 8'hA5);
    sel();
    send(8'h03); send(8'h00); send(8'h30); xfer(8'h00, 8, rx);
    desel();
    check("ign_next_read", {8'h0, rx}, 16'h0011);

    sel();
    send(8'h02); send(8'h00); send(8'h40); send(8'h5A);
    desel();
    s0 = strobes;
    sel();
    send(8'h02); send(8'h00); send(8'h40); xfer(8'hFF, 4, rx);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", {15'h0, busy}, 16'h0);
    repeat (8) @(negedge clk);
    peek(8'h40, "abort_dbg40", 8'h5A);
    check("abort_strobes", 16'(strobes - s0), 16'd0);

    sel();
    send(8'h02); send(8'h00); xfer(8'h50, 3, rx);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {15'h0, busy}, 16'h0);
    check("mid_rst_oe", {15'h0, oe}, 16'h0);
    check("mid_rst_miso", {15'h0, miso}, 16'h0);
    check("mid_rst_strobe", {15'h0, wr_strobe}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    desel();
    s0 = strobes;
    sel();
    send(8'h02); send(8'h00); send(8'h50); send(8'h3C);
    desel();
    check("post_rst_strobes", 16'(strobes - s0), 16'd1);
    peek(8'h50, "post_rst_dbg50", 8'h3C);
    sel();
    send(8'h03); send(8'h00); send(8'h50); xfer(8'h00, 8, rx);
    desel();
    check("post_rst_read", {8'h0, rx}, 16'h003C);
    check("miso_only_after_fall", 16'(miso_moves), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- SPI Mode 0 (CPOL=0, CPHA=0) slave that emulates a 23LC512-style serial RAM: READ (0x03) / WRITE (0x02), 16-bit address MSB first, sequential data bytes with address auto-increment.
- Other end of the bus driven by the core's SPI master; used for on-chip loopback, FPGA RAM emulation and as the bench memory model.
- Fully synchronous to the core clock; SCLK/CS/MOSI are oversampled, never used as clocks.

Parameters:
- ADDR_WIDTH, 8, log2 of the internal byte array depth (256 bytes); the 16-bit bus address is taken modulo 2^ADDR_WIDTH.
- SYNC_STAGES, 2, synchronizer flops on spi_sclk_i, spi_cs_i and spi_mosi_i (minimum 2).

Ports:
- clk_core_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- spi_sclk_i  in  1  SPI clock from master
- spi_cs_i  in  1  chip select, active low
- spi_mosi_i  in  1  master-out data
- spi_miso_o  out  1  slave-out data
- spi_miso_oe_o  out  1  MISO output enable, high while selected
- dbg_addr_i  in  ADDR_WIDTH  backdoor read address
- dbg_data_o  out  8  backdoor read data, combinational from the array
- wr_strobe_o  out  1  one-cycle pulse when a byte is committed to the array
- busy_o  out  1  high while CS is asserted (synchronized)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: spi_miso_o=0, spi_miso_oe_o=0, wr_strobe_o=0, busy_o=0, FSM=ST_IDLE, bit counter=7, shift registers=0. Array contents are not reset.
- Synchronizers: inputs pass through SYNC_STAGES flops. Edges are detected against the previous synchronized SCLK sample.
- Master SCLK half period must be at least SYNC_STAGES+2 core cycles; CLOCK_DIVIDER>=4 at the default.
- CS: a synchronized deassert takes priority over everything in the same cycle. It forces ST_IDLE, discards any partial byte (no write), drives spi_miso_o=0 and clears oe and busy on the next cycle.
- Sampling: MOSI is shifted in MSB first on each synchronized SCLK rising edge. The bit counter counts 7 down to 0; a byte completes on the rising edge at count 0, then the counter reloads to 7.
- FSM states:
  - ST_IDLE: enter ST_CMD one cycle after synchronized CS falls.
  - ST_CMD: on byte completion, 0x03 goes to ST_ADDR_HI with read flag set; 0x02 goes to ST_ADDR_HI with read flag clear; any other value goes to ST_IGNORE.
  - ST_ADDR_HI: on byte completion, latch addr[15:8], go to ST_ADDR_LO.
  - ST_ADDR_LO: on byte completion, latch addr[7:0]. Read: load the MISO shift register with mem[addr], go to ST_READ. Write: go to ST_WRITE.
  - ST_READ:
    - spi_miso_o is updated only after each synchronized falling edge, to the next bit MSB first.
    - The first data bit is driven after the falling edge that ends the last address bit.
    - After the 8th data falling edge: addr increments, and the shift register reloads with mem[addr+1] before that byte's first bit is presented.
  - ST_WRITE: on byte completion, mem[addr]<=byte, wr_strobe_o pulses for exactly 1 cycle, addr increments.
  - ST_IGNORE: MOSI ignored, spi_miso_o=0, until CS deasserts.
- Address: the 16-bit register wraps 0xFFFF to 0x0000. The array index is addr[ADDR_WIDTH-1:0], so with ADDR_WIDTH=8, 0x00FF is followed by 0x0100, which aliases to index 0x00.
- Outside ST_READ, spi_miso_o=0. spi_miso_oe_o equals the synchronized ~CS.
- Backdoor: dbg_data_o reads mem[dbg_addr_i] asynchronously. A same-cycle write is visible only on the following cycle.
- SCLK edges while CS is high are ignored. Asserting rst_i mid-transaction returns to ST_IDLE immediately, with no write.

Decomposition:
- Shared package spi_ram_pkg: CMD_READ=8'h03, CMD_WRITE=8'h02, and state encodings. The existing master reuses the command constants.
- One sub-module, sync_edge_detect: an N-stage synchronizer producing rise/fall pulses, instantiated for SCLK and CS (MOSI uses the synchronizer only).

Test Plan:
- WRITE 0x02,0x00,0x12,0xA5 with the master at CLOCK_DIVIDER=4 -> one wr_strobe_o pulse; dbg_addr_i=0x12 returns 0xA5. A subsequent 1-byte READ of 0x0012 returns data_read_byte1_o=0xA5.
- Preload 0x30=0x11, 0x31=0x22; 2-byte READ at 0x0030 -> byte1=0x11, byte2=0x22; MISO changes only after SCLK falling edges.
- ADDR_WIDTH=8: preload 0xFF=0x7E, 0x00=0x81; 2-byte READ at 0x00FF -> 0x7E then 0x81 (wrap).
- Command 0x05 followed by 24 clocks -> MISO stays 0, no wr_strobe_o, array unchanged; next valid READ works normally.
- WRITE to 0x0040 with CS deasserted after 4 data bits -> no strobe, mem[0x40] unchanged, busy_o drops within SYNC_STAGES+1 cycles.
- Assert rst_i during ST_ADDR_LO -> outputs return to reset values immediately; the next full transaction succeeds.
